// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// Mode encodings and the stage-count helper used by the RTL and benches.
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Pipeline depth: one stage per SEG-bit segment.
  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead slice: every carry is a flat
// sum-of-products of generate/propagate terms rather than a ripple chain.
module cla_seg #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]ci
  always_comb begin
    logic term;
    // NOTE: every variable assigned here gets a default first so no path leaves it unassigned (no latch).
    c    = '0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i];
      term   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (term & g[j]);
        term   = term & p[j];
      end
      c[i+1] = c[i+1] | (term & ci);
    end
  end

  assign s     = p ^ c[SEG-1:0];
  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SEG-bit segment per stage,
// carry registered between stages, valid/ready handshake with global stall.
module pipe_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int MSB  = WIDTH - 1;

  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("pipe_cla_adder: WIDTH must be a multiple of SEG");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Stage registers: skewed operands, partial sum, carry out, valid.
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];
  logic             c_q [NSEG];
  logic             v_q [NSEG];
  logic             ovf_q;

  logic [WIDTH-1:0] a_in   [NSEG];
  logic [WIDTH-1:0] b_in   [NSEG];
  logic [WIDTH-1:0] s_in   [NSEG];
  logic [WIDTH-1:0] s_next [NSEG];
  logic             c_in   [NSEG];
  logic [SEG-1:0]   s_seg  [NSEG];
  logic [NSEG-1:0]  co;
  logic [NSEG-1:0]  c_msb;
  logic             ovf_next;
  logic             unused_c_msb;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1; cin only matters in add mode.
  assign b_eff = (sub == SUB) ? ~in2 : in2;
  assign c0    = (sub == SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}}) << (k * SEG);

    if (k == 0) begin : g_first
      assign a_in[k] = in1;
      assign b_in[k] = b_eff;
      assign c_in[k] = c0;
      assign s_in[k] = '0;
    end else begin : g_next
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    cla_seg #(.SEG(SEG)) u_seg (
      .a     (a_in[k][k*SEG +: SEG]),
      .b     (b_in[k][k*SEG +: SEG]),
      .ci    (c_in[k]),
      .s     (s_seg[k]),
      .co    (co[k]),
      .c_msb (c_msb[k])
    );

    assign s_next[k] = (s_in[k] & ~SEG_MASK) | (WIDTH'(s_seg[k]) << (k * SEG));
  end

  // Overflow from the sign bits seen by the last stage.
  assign ovf_next = (a_in[NSEG-1][MSB] == b_in[NSEG-1][MSB]) &&
                    (s_next[NSEG-1][MSB] != a_in[NSEG-1][MSB]);

  assign unused_c_msb = ^c_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so sum/cout/ovf read zero out of reset.
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments so every stage shifts from pre-edge values.
      v_q[0] <= in_valid;
      for (int k = 1; k < NSEG; k++) begin
        v_q[k] <= v_q[k-1];
      end
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_next[k];
        c_q[k] <= co[k];
      end
      ovf_q <= ovf_next;
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign sum       = s_q[NSEG-1];
  assign cout      = c_q[NSEG-1];
  assign ovf       = ovf_q;

endmodule
